// File: rtl/fare_collect.sv
// Coin-payment session controller: receives a three-beat fare frame from the
// button scanner, collects coins, then issues a ticket with change or refunds.
module fare_collect #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned TW          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy_in,
    input  logic [7:0] data_in,
    input  logic       cmp_in,
    input  logic [3:0] coin,
    input  logic       cancel,
    output logic       busy,
    output logic [7:0] due,
    output logic [7:0] paid,
    output logic       ticket,
    output logic [7:0] ticket_dst,
    output logic       change_vld,
    output logic [7:0] change_val,
    output logic       refund,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_FEE,
        S_RX_DST,
        S_RX_END,
        S_COLLECT,
        S_DISPENSE,
        S_REFUND
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    fee_q, fee_d;
    logic [7:0]    dst_q, dst_d;
    logic [7:0]    due_q, due_d;
    logic [7:0]    paid_q, paid_d;
    logic [7:0]    tdst_q, tdst_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    chg_val_q, chg_val_d;
    logic          chg_vld_q, chg_vld_d;
    logic          ticket_q, ticket_d;
    logic          refund_q, refund_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;

    logic [7:0]    coin_val;
    logic          coin_ok;
    logic [8:0]    sum9;
    logic [7:0]    paid_new;

    // Only a strictly one-hot coin carries credit.
    always_comb begin
        case (coin)
            4'b0001: coin_val = 8'd1;
            4'b0010: coin_val = 8'd2;
            4'b0100: coin_val = 8'd5;
            4'b1000: coin_val = 8'd10;
            default: coin_val = 8'd0;
        endcase
    end

    assign coin_ok  = (coin_val != 8'd0);
    assign sum9     = {1'b0, paid_q} + {1'b0, coin_val};
    assign paid_new = sum9[8] ? 8'hFF : sum9[7:0];

    always_comb begin
        state_d   = state_q;
        fee_d     = fee_q;
        dst_d     = dst_q;
        due_d     = due_q;
        paid_d    = paid_q;
        tdst_d    = tdst_q;
        timer_d   = timer_q;
        chg_val_d = chg_val_q;
        chg_vld_d = 1'b0;
        ticket_d  = 1'b0;
        refund_d  = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rdy_in) state_d = S_RX_FEE;
            end
            S_RX_FEE: begin
                if (rdy_in) begin
                    fee_d   = data_in;
                    state_d = S_RX_DST;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RX_DST: begin
                if (rdy_in) begin
                    dst_d   = data_in;
                    state_d = S_RX_END;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RX_END: begin
                if (cmp_in) begin
                    if (fee_q == 8'd0) begin
                        ferr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        due_d   = fee_q;
                        tdst_d  = dst_q;
                        paid_d  = '0;
                        timer_d = '0;
                        state_d = S_COLLECT;
                    end
                end else if (!rdy_in) begin
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (coin_ok) begin
                    paid_d  = paid_new;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                // Cancel takes priority; a coin on the same edge is already in paid_d.
                if (cancel)
                    state_d = S_REFUND;
                else if (coin_ok && (paid_new >= due_q))
                    state_d = S_DISPENSE;
                else if (!coin_ok && (timer_q == TW'(TIMEOUT_CYC - 1)))
                    state_d = S_REFUND;
            end
            S_DISPENSE: begin
                ticket_d  = 1'b1;
                chg_val_d = paid_q - due_q;
                chg_vld_d = (paid_q != due_q);
                paid_d    = '0;
                due_d     = '0;
                state_d   = S_IDLE;
            end
            S_REFUND: begin
                refund_d  = 1'b1;
                chg_val_d = paid_q;
                chg_vld_d = (paid_q != 8'd0);
                paid_d    = '0;
                due_d     = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fee_q     <= '0;
            dst_q     <= '0;
            due_q     <= '0;
            paid_q    <= '0;
            tdst_q    <= '0;
            timer_q   <= '0;
            chg_val_q <= '0;
            chg_vld_q <= 1'b0;
            ticket_q  <= 1'b0;
            refund_q  <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fee_q     <= fee_d;
            dst_q     <= dst_d;
            due_q     <= due_d;
            paid_q    <= paid_d;
            tdst_q    <= tdst_d;
            timer_q   <= timer_d;
            chg_val_q <= chg_val_d;
            chg_vld_q <= chg_vld_d;
            ticket_q  <= ticket_d;
            refund_q  <= refund_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign due        = due_q;
    assign paid       = paid_q;
    assign ticket     = ticket_q;
    assign ticket_dst = tdst_q;
    assign change_vld = chg_vld_q;
    assign change_val = chg_val_q;
    assign refund     = refund_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_fare_collect.sv
// Bench for fare_collect: directed scenarios plus randomized coin sessions
// checked against a session-level arithmetic model.
module tb_fare_collect;

    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy_in;
    logic [7:0] data_in;
    logic       cmp_in;
    logic [3:0] coin;
    logic       cancel;
    logic       busy;
    logic [7:0] due;
    logic [7:0] paid;
    logic       ticket;
    logic [7:0] ticket_dst;
    logic       change_vld;
    logic [7:0] change_val;
    logic       refund;
    logic       frame_err;

    fare_collect #(.TIMEOUT_CYC(TO), .TW(4)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .data_in(data_in), .cmp_in(cmp_in),
        .coin(coin), .cancel(cancel), .busy(busy), .due(due), .paid(paid),
        .ticket(ticket), .ticket_dst(ticket_dst), .change_vld(change_vld),
        .change_val(change_val), .refund(refund), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int due_m, paid_m, dst_m, idle_m;
    bit in_session;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_amt(input logic [3:0] c);
        case (c)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 5;
            4'b1000: return 10;
            default: return 0;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_due"}, due, 0);
        chk({tag, "_paid"}, paid, 0);
        chk({tag, "_ticket"}, ticket, 0);
        chk({tag, "_ticket_dst"}, ticket_dst, 0);
        chk({tag, "_change_vld"}, change_vld, 0);
        chk({tag, "_change_val"}, change_val, 0);
        chk({tag, "_refund"}, refund, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
    endtask

    task automatic send_frame(input int fee, input int dst, input int hold);
        rdy_in = 1'b1; data_in = 8'd0;
        tick;
        chk("busy_after_E0", busy, 1);
        data_in = fee[7:0];
        tick;
        data_in = dst[7:0];
        tick;
        data_in = 8'd0;
        for (int i = 0; i < hold; i++) begin
            tick;
            chk("busy_rx_end_hold", busy, 1);
        end
        rdy_in = 1'b0; cmp_in = 1'b1;
        tick;
        cmp_in = 1'b0;
        if (fee != 0) begin
            due_m = fee; paid_m = 0; dst_m = dst; idle_m = 0; in_session = 1;
            chk("due_after_commit", due, fee);
            chk("paid_after_commit", paid, 0);
            chk("busy_collect", busy, 1);
            chk("no_ferr_good_frame", frame_err, 0);
        end else begin
            chk("ferr_fee0", frame_err, 1);
            chk("busy_fee0", busy, 0);
            chk("due_fee0", due, 0);
            tick;
            chk("ferr_fee0_oneshot", frame_err, 0);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick;
            chk("no_early_refund", refund, 0);
            idle_m++;
        end
    endtask

    task automatic coin_step(input logic [3:0] c, input logic cx);
        coin = c; cancel = cx;
        tick;
        coin = 4'd0; cancel = 1'b0; rdy_in = 1'b0; cmp_in = 1'b0;
        paid_m = paid_m + coin_amt(c);
        if (paid_m > 255) paid_m = 255;
        if (coin_amt(c) != 0) idle_m = 0; else idle_m++;
        chk("paid_after_coin", paid, paid_m);
        if (cx || paid_m >= due_m) begin
            chk("strobe_not_early", {ticket, refund}, 0);
            tick;
            if (cx) begin
                chk("refund_cancel", refund, 1);
                chk("no_ticket_cancel", ticket, 0);
                chk("refund_change_val", change_val, paid_m);
                chk("refund_change_vld", change_vld, (paid_m != 0) ? 1 : 0);
            end else begin
                chk("ticket", ticket, 1);
                chk("no_refund_dispense", refund, 0);
                chk("ticket_dst", ticket_dst, dst_m);
                chk("change_val", change_val, paid_m - due_m);
                chk("change_vld", change_vld, (paid_m != due_m) ? 1 : 0);
            end
            chk("busy_end", busy, 0);
            chk("due_end", due, 0);
            chk("paid_end", paid, 0);
            tick;
            chk("ticket_oneshot", ticket, 0);
            chk("refund_oneshot", refund, 0);
            chk("change_vld_oneshot", change_vld, 0);
            in_session = 0;
        end
    endtask

    initial begin
        logic [3:0] c;
        int gap, steps;
        rst = 1'b1; rdy_in = 1'b0; data_in = 8'd0; cmp_in = 1'b0; coin = 4'd0; cancel = 1'b0;
        in_session = 0;
        #12;
        check_zero("reset");
        tick;
        rst = 1'b0;
        tick;
        check_zero("post_reset_idle");

        // Change given: 23 paid with 10+10+5.
        send_frame(23, 2, 0);
        coin_step(4'b1000, 1'b0);
        coin_step(4'b1000, 1'b0);
        coin_step(4'b0100, 1'b0);

        // Exact payment, destination held from the frame.
        send_frame(16, 77, 1);
        coin_step(4'b1000, 1'b0);
        coin_step(4'b0100, 1'b0);
        coin_step(4'b0001, 1'b0);
        chk("ticket_dst_held", ticket_dst, 77);

        // Cancel together with a coin refunds the coin too.
        send_frame(44, 5, 0);
        coin_step(4'b1000, 1'b0);
        coin_step(4'b1000, 1'b0);
        coin_step(4'b0100, 1'b1);

        // Inactivity timeout: REFUND entered TO edges after the coin, strobe one edge later.
        send_frame(30, 6, 0);
        coin_step(4'b0010, 1'b0);
        idle_cycles(TO);
        tick;
        chk("timeout_refund", refund, 1);
        chk("timeout_change_val", change_val, 2);
        chk("timeout_change_vld", change_vld, 1);
        chk("timeout_no_ticket", ticket, 0);
        chk("timeout_busy", busy, 0);
        tick;
        chk("timeout_refund_oneshot", refund, 0);
        in_session = 0;

        // Malformed frames.
        rdy_in = 1'b1; tick; rdy_in = 1'b0; tick;
        chk("ferr_drop_fee", frame_err, 1);
        chk("busy_drop_fee", busy, 0);
        tick;
        chk("ferr_oneshot", frame_err, 0);
        rdy_in = 1'b1; tick; data_in = 8'd9; tick; rdy_in = 1'b0; tick;
        chk("ferr_drop_dst", frame_err, 1);
        rdy_in = 1'b1; tick; tick; tick; rdy_in = 1'b0; tick;
        chk("ferr_rx_end_low", frame_err, 1);
        chk("due_rx_end_low", due, 0);
        tick;
        send_frame(0, 3, 0);

        // Multi-hot coin gives no credit.
        send_frame(20, 1, 0);
        coin_step(4'b0011, 1'b0);
        coin_step(4'b0000, 1'b0);
        coin_step(4'b1000, 1'b0);
        coin_step(4'b1010, 1'b0);
        coin_step(4'b1000, 1'b0);

        // Saturating sum near the top of the fee range.
        send_frame(253, 200, 0);
        for (int i = 0; i < 26; i++) coin_step(4'b1000, 1'b0);
        chk("sat_session_done", in_session, 0);

        // Asynchronous reset mid-session, then a fresh frame.
        send_frame(40, 9, 0);
        coin_step(4'b1000, 1'b0);
        coin_step(4'b0100, 1'b0);
        chk("paid_before_rst", paid, 15);
        #2 rst = 1'b1;
        #1;
        check_zero("mid_rst");
        tick;
        rst = 1'b0;
        tick;
        chk("no_refund_after_rst", refund, 0);
        send_frame(5, 3, 0);
        coin_step(4'b0100, 1'b0);

        // Randomized sessions; frame inputs toggle during COLLECT and must be ignored.
        for (int s = 0; s < 20; s++) begin
            send_frame($urandom_range(1, 60), $urandom_range(0, 255), $urandom_range(0, 2));
            steps = 0;
            while (in_session && steps < 100) begin
                gap = $urandom_range(0, 2);
                if ($urandom_range(0, 9) == 0 && idle_m + gap + 1 <= 5) begin
                    case ($urandom_range(0, 2))
                        0: c = 4'b0011;
                        1: c = 4'b1100;
                        default: c = 4'b1111;
                    endcase
                end else begin
                    c = 4'b0001 << $urandom_range(0, 3);
                end
                if (idle_m + gap > 5) gap = 0;
                idle_cycles(gap);
                rdy_in = 1'($urandom_range(0, 1));
                cmp_in = 1'($urandom_range(0, 1));
                data_in = 8'($urandom_range(0, 255));
                coin_step(c, ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
                steps++;
            end
            chk("random_session_ended", in_session, 0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
